rpn_engine: RTL and testbench

Reverse-Polish evaluation engine that sits directly upstream of the `stack` block and is its sole driver. It accepts a stream of operand/operator tokens over a valid/ready handshake and translates each token into push/pop sequences on the stack. It computes binary results and returns them to the stack. It presents popped results on a one-cycle result strobe and reports underflow/overflow through a sticky error flag.

---
 rtl/rpn_pkg.sv | 34 +++
 rtl/rpn_alu.sv | 29 ++
 rtl/rpn_engine.sv | 182 ++++++++++++++++++
 tb/tb_rpn_engine.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared definitions for the RPN evaluation engine.
//   tok_e   - token opcodes carried on tok_type
//   state_e - engine FSM states
//   ERR_*   - error codes reported on err_code
package rpn_pkg;

  typedef enum logic [2:0] {
    TOK_PUSH   = 3'b000,
    TOK_ADD    = 3'b001,
    TOK_SUB    = 3'b010,
    TOK_AND    = 3'b011,
    TOK_OR     = 3'b100,
    TOK_XOR    = 3'b101,
    TOK_RESULT = 3'b110,
    TOK_CLEAR  = 3'b111
  } tok_e;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_PUSH  = 4'd1,
    S_POP_B = 4'd2,
    S_CAP_B = 4'd3,
    S_CAP_A = 4'd4,
    S_WB    = 4'd5,
    S_OUT   = 4'd6,
    S_CLR   = 4'd7,
    S_ERR   = 4'd8
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational binary operator for the RPN engine.
//   a_i  - operand second from the top of the stack
//   b_i  - operand on top of the stack
//   op_i - token opcode selecting the operation
//   y_o  - result, mod 2^WIDTH (carry/borrow dropped)
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  tok_e             op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      TOK_ADD: y_o = a_i + b_i;
      TOK_SUB: y_o = a_i - b_i;
      TOK_AND: y_o = a_i & b_i;
      TOK_OR:  y_o = a_i | b_i;
      TOK_XOR: y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rpn_engine.sv
// rpn_engine: Reverse-Polish evaluation engine, sole driver of a stack block.
//   clk, reset           - clock; synchronous active-low reset
//   tok_valid/tok_ready  - token handshake; tok_type opcode, tok_data operand
//   stk_push/stk_pop     - stack strobes (never both high), stk_din write data
//   stk_dout             - popped value, valid the cycle after a pop
//   stk_full/stk_empty   - stack status flags
//   res_valid/res_data   - one-cycle result strobe, data held between strobes
//   err/err_code         - sticky error flag and first error code
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [2:0]       tok_type,
  input  logic [WIDTH-1:0] tok_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [1:0]       err_code
);

  state_e           state_q, state_d;
  tok_e             op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [WIDTH-1:0] alu_y;
  logic             accept;
  logic             push_raw, pop_raw;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  // Ready is held low throughout reset so no token can slip in at the reset edge.
  assign tok_ready = reset && ((state_q == S_IDLE) || (state_q == S_ERR));
  assign accept    = tok_valid && tok_ready;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    err_d     = err_q;
    code_d    = code_q;
    push_raw  = 1'b0;
    pop_raw   = 1'b0;
    stk_din   = '0;
    res_valid = 1'b0;

    if (accept) begin
      op_d   = tok_e'(tok_type);
      data_d = tok_data;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (tok_e'(tok_type))
            TOK_PUSH:  state_d = S_PUSH;
            TOK_CLEAR: state_d = S_CLR;
            default:   state_d = S_POP_B;  // RESULT and all binary ops
          endcase
        end
      end
      S_PUSH: begin
        if (stk_full) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_OVER;
        end else begin
          push_raw = 1'b1;
          stk_din  = data_q;
          state_d  = S_IDLE;
        end
      end
      S_POP_B: begin
        if (stk_empty) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_UNDER;
        end else begin
          pop_raw = 1'b1;
          state_d = S_CAP_B;
        end
      end
      S_CAP_B: begin
        if (op_q == TOK_RESULT) begin
          res_d   = stk_dout;
          state_d = S_OUT;
        end else if (stk_empty) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_UNDER;
        end else begin
          b_d     = stk_dout;
          pop_raw = 1'b1;
          state_d = S_CAP_A;
        end
      end
      S_CAP_A: begin
        a_d     = stk_dout;
        state_d = S_WB;
      end
      S_WB: begin
        // Two entries were just popped, so there is always room here.
        push_raw = 1'b1;
        stk_din  = alu_y;
        state_d  = S_IDLE;
      end
      S_OUT: begin
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_CLR: begin
        if (!stk_empty) begin
          pop_raw = 1'b1;
        end else begin
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        // Everything except CLEAR is consumed and dropped.
        if (accept && (tok_e'(tok_type) == TOK_CLEAR)) begin
          state_d = S_CLR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset aborts at once: no strobe reaches the stack in the reset cycle.
  assign stk_push = push_raw && reset;
  assign stk_pop  = pop_raw && reset;

  assign res_data = res_q;
  assign err      = err_q;
  assign err_code = code_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= TOK_PUSH;
      data_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_rpn_engine.sv
// tb_rpn_engine: self-checking bench for rpn_engine with a behavioural
// 8-deep stack attached and a queue-based token reference model.
module tb_rpn_engine;

  localparam logic [2:0] T_PUSH = 3'd0, T_ADD = 3'd1, T_SUB = 3'd2, T_AND = 3'd3,
                         T_OR = 3'd4, T_XOR = 3'd5, T_RESULT = 3'd6, T_CLEAR = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic [2:0] tok_type = 3'd0;
  logic [7:0] tok_data = 8'd0;
  logic       stk_push, stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;
  logic       stk_full, stk_empty;
  logic       res_valid;
  logic [7:0] res_data;
  logic       err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rpn_engine #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_type  (tok_type),
    .tok_data  (tok_data),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .err_code  (err_code)
  );

  // Behavioural stack, WIDTH 8, DEPTH 8.
  logic [7:0] smem [8];
  int scnt = 0;
  always @(posedge clk) begin
    if (!reset) begin
      scnt     <= 0;
      stk_dout <= 8'h00;
    end else if (stk_push && scnt < 8) begin
      smem[scnt[2:0]] <= stk_din;
      scnt            <= scnt + 1;
    end else if (stk_pop && scnt > 0) begin
      stk_dout <= smem[3'(scnt - 1)];
      scnt     <= scnt - 1;
    end
  end
  assign stk_full  = (scnt == 8);
  assign stk_empty = (scnt == 0);

  // Monitor
  int cyc = 0;
  int res_cyc = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  bit both_hi = 1'b0;
  logic [7:0] got_res[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (res_valid) begin
      got_res.push_back(res_data);
      res_cyc <= cyc;
    end
    if (stk_push) push_cnt <= push_cnt + 1;
    if (stk_pop) pop_cnt <= pop_cnt + 1;
    if (stk_push && stk_pop) both_hi <= 1'b1;
  end

  // Reference model: plain RPN semantics on a queue.
  logic [7:0] m_q[$];
  logic [7:0] exp_res[$];
  logic       m_err = 1'b0;
  logic [1:0] m_code = 2'b00;
  int         acc_cyc = 0;

  task automatic model_reset();
    m_q.delete();
    exp_res.delete();
    got_res.delete();
    m_err = 1'b0;
    m_code = 2'b00;
  endtask

  task automatic model_tok(input logic [2:0] t, input logic [7:0] d);
    logic [7:0] a, b, r;
    if (m_err) begin
      if (t == T_CLEAR) begin
        m_q.delete();
        m_err = 1'b0;
        m_code = 2'b00;
      end
    end else if (t == T_PUSH) begin
      if (m_q.size() == 8) begin
        m_err = 1'b1;
        m_code = 2'b10;
      end else m_q.push_back(d);
    end else if (t == T_CLEAR) begin
      m_q.delete();
    end else if (t == T_RESULT) begin
      if (m_q.size() == 0) begin
        m_err = 1'b1;
        m_code = 2'b01;
      end else exp_res.push_back(m_q.pop_back());
    end else begin
      if (m_q.size() < 2) begin
        if (m_q.size() == 1) void'(m_q.pop_back());
        m_err = 1'b1;
        m_code = 2'b01;
      end else begin
        b = m_q.pop_back();
        a = m_q.pop_back();
        case (t)
          T_ADD:   r = a + b;
          T_SUB:   r = a - b;
          T_AND:   r = a & b;
          T_OR:    r = a | b;
          default: r = a ^ b;
        endcase
        m_q.push_back(r);
      end
    end
  endtask

  // Presents a token and returns just after its accept edge.
  task automatic send_tok(input logic [2:0] t, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tok_type = t;
    tok_data = d;
    tok_valid = 1'b1;
    while (tok_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (tok_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tok_ready=%b required 1", tok_ready);
      tok_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      tok_valid = 1'b0;
      acc_cyc = cyc;
      model_tok(t, d);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (tok_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (tok_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: tok_ready=%b required 1", tok_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (tok_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 0", tok_ready);
    end
    n_checks++;
    if ({stk_push, stk_pop, res_valid, err, err_code} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000", {stk_push, stk_pop, res_valid, err, err_code});
    end
    n_checks++;
    if ({stk_din, res_data} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0000", {stk_din, res_data});
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tok_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: got %b required 1", tok_ready);
    end
  endtask

  task automatic test_add();
    logic [7:0] g, e;
    send_tok(T_PUSH, 8'd10);
    send_tok(T_PUSH, 8'd20);
    send_tok(T_ADD, 8'd0);
    send_tok(T_RESULT, 8'd0);
    wait_ready();
    n_checks++;
    if (got_res.size() != exp_res.size()) begin
      n_fail++;
      $display("FAIL add_res_count: got %0d required %0d", got_res.size(), exp_res.size());
    end
    while (got_res.size() > 0 && exp_res.size() > 0) begin
      g = got_res.pop_front();
      e = exp_res.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL add_res: got %0d required %0d", g, e);
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (res_data !== 8'd30) begin
      n_fail++;
      $display("FAIL add_res_hold: got %0d required 30", res_data);
    end
    n_checks++;
    if (stk_empty !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL add_after: empty=%b err=%b required 1 0", stk_empty, err);
    end
  endtask

  task automatic test_sub_xor();
    logic [7:0] g, e;
    send_tok(T_PUSH, 8'd5);
    send_tok(T_PUSH, 8'd7);
    send_tok(T_SUB, 8'd0);
    send_tok(T_RESULT, 8'd0);
    send_tok(T_PUSH, 8'hF0);
    send_tok(T_PUSH, 8'h3C);
    send_tok(T_XOR, 8'd0);
    send_tok(T_RESULT, 8'd0);
    wait_ready();
    n_checks++;
    if (got_res.size() != exp_res.size()) begin
      n_fail++;
      $display("FAIL subxor_res_count: got %0d required %0d", got_res.size(), exp_res.size());
    end
    while (got_res.size() > 0 && exp_res.size() > 0) begin
      g = got_res.pop_front();
      e = exp_res.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL subxor_res: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3, a4, a5, a7;
    logic [7:0] g, e;
    send_tok(T_PUSH, 8'h11);
    a1 = acc_cyc;
    n_checks++;
    if (stk_push !== 1'b1 || stk_din !== 8'h11) begin
      n_fail++;
      $display("FAIL push_latency: push=%b din=%h required 1 11", stk_push, stk_din);
    end
    send_tok(T_PUSH, 8'h2E);
    a2 = acc_cyc;
    send_tok(T_OR, 8'h00);
    a3 = acc_cyc;
    send_tok(T_RESULT, 8'h00);
    a4 = acc_cyc;
    send_tok(T_PUSH, 8'h33);
    a5 = acc_cyc;
    send_tok(T_PUSH, 8'h44);
    send_tok(T_CLEAR, 8'h00);
    a7 = acc_cyc;
    send_tok(T_PUSH, 8'h55);
    n_checks++;
    if ({a2 - a1, a3 - a2, a4 - a3, a5 - a4} !== {32'd2, 32'd2, 32'd5, 32'd4}) begin
      n_fail++;
      $display("FAIL spacing: got %0d %0d %0d %0d required 2 2 5 4", a2 - a1, a3 - a2, a4 - a3, a5 - a4);
    end
    n_checks++;
    if (acc_cyc - a7 !== 4) begin
      n_fail++;
      $display("FAIL clear_spacing: got %0d required 4", acc_cyc - a7);
    end
    n_checks++;
    if (res_cyc - a4 !== 2) begin
      n_fail++;
      $display("FAIL res_latency: got %0d required 2", res_cyc - a4);
    end
    send_tok(T_CLEAR, 8'h00);
    wait_ready();
    n_checks++;
    if (got_res.size() != exp_res.size()) begin
      n_fail++;
      $display("FAIL b2b_res_count: got %0d required %0d", got_res.size(), exp_res.size());
    end
    while (got_res.size() > 0 && exp_res.size() > 0) begin
      g = got_res.pop_front();
      e = exp_res.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_res: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_underflow();
    int p0;
    send_tok(T_PUSH, 8'd3);
    wait_ready();
    p0 = push_cnt;
    send_tok(T_ADD, 8'd0);
    wait_ready();
    n_checks++;
    if ({err, err_code} !== {m_err, m_code} || {err, err_code} !== 3'b101) begin
      n_fail++;
      $display("FAIL underflow_err: got %b%b required %b%b", err, err_code, m_err, m_code);
    end
    n_checks++;
    if (stk_empty !== 1'b1 || push_cnt !== p0) begin
      n_fail++;
      $display("FAIL underflow_stack: empty=%b pushes=%0d required 1 %0d", stk_empty, push_cnt, p0);
    end
    send_tok(T_CLEAR, 8'd0);
    wait_ready();
    send_tok(T_RESULT, 8'd0);
    wait_ready();
    n_checks++;
    if ({err, err_code} !== 3'b101 || got_res.size() != 0) begin
      n_fail++;
      $display("FAIL result_underflow: got %b%b res=%0d required 101 0", err, err_code, got_res.size());
    end
    send_tok(T_CLEAR, 8'd0);
    wait_ready();
    n_checks++;
    if ({err, err_code} !== 3'b000) begin
      n_fail++;
      $display("FAIL underflow_clear: got %b%b required 000", err, err_code);
    end
  endtask

  task automatic test_overflow_and_err();
    int p0, q0;
    bit ok;
    logic [7:0] g, e;
    for (int i = 1; i <= 9; i++) send_tok(T_PUSH, 8'(i));
    wait_ready();
    n_checks++;
    if ({err, err_code} !== {m_err, m_code} || err_code !== 2'b10) begin
      n_fail++;
      $display("FAIL overflow_err: got %b%b required %b%b", err, err_code, m_err, m_code);
    end
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (smem[i[2:0]] !== m_q[i]) ok = 1'b0;
    n_checks++;
    if (!ok || stk_full !== 1'b1 || scnt !== m_q.size()) begin
      n_fail++;
      $display("FAIL overflow_stack: contents_ok=%b full=%b depth=%0d required 1 1 %0d", ok, stk_full, scnt, m_q.size());
    end
    p0 = push_cnt;
    q0 = pop_cnt;
    send_tok(T_PUSH, 8'd4);
    send_tok(T_ADD, 8'd0);
    wait_ready();
    n_checks++;
    if (push_cnt !== p0 || pop_cnt !== q0 || scnt !== 8 || {err, err_code} !== 3'b110) begin
      n_fail++;
      $display("FAIL err_drop: pushes=%0d pops=%0d depth=%0d err=%b%b required %0d %0d 8 110",
               push_cnt, pop_cnt, scnt, err, err_code, p0, q0);
    end
    send_tok(T_CLEAR, 8'd0);
    wait_ready();
    n_checks++;
    if (pop_cnt - q0 !== 8 || stk_empty !== 1'b1 || {err, err_code} !== 3'b000) begin
      n_fail++;
      $display("FAIL clear: pops=%0d empty=%b err=%b%b required 8 1 000", pop_cnt - q0, stk_empty, err, err_code);
    end
    send_tok(T_PUSH, 8'd1);
    send_tok(T_RESULT, 8'd0);
    wait_ready();
    n_checks++;
    if (got_res.size() != exp_res.size() || exp_res.size() != 1) begin
      n_fail++;
      $display("FAIL after_clear_count: got %0d required 1", got_res.size());
    end
    while (got_res.size() > 0 && exp_res.size() > 0) begin
      g = got_res.pop_front();
      e = exp_res.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL after_clear_res: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] g, e;
    int r;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 19);
      if (m_q.size() == 0 || (r < 8 && m_q.size() < 8)) send_tok(T_PUSH, 8'($urandom));
      else if (r < 16 && m_q.size() >= 2) send_tok(3'($urandom_range(1, 5)), 8'($urandom));
      else if (r == 19) send_tok(T_CLEAR, 8'($urandom));
      else send_tok(T_RESULT, 8'($urandom));
    end
    wait_ready();
    n_checks++;
    if (err !== m_err || scnt !== m_q.size()) begin
      n_fail++;
      $display("FAIL random_state: err=%b depth=%0d required %b %0d", err, scnt, m_err, m_q.size());
    end
    n_checks++;
    if (got_res.size() != exp_res.size()) begin
      n_fail++;
      $display("FAIL random_res_count: got %0d required %0d", got_res.size(), exp_res.size());
    end
    while (got_res.size() > 0 && exp_res.size() > 0) begin
      g = got_res.pop_front();
      e = exp_res.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL random_res: got %h required %h", g, e);
      end
    end
    send_tok(T_CLEAR, 8'd0);
    wait_ready();
  endtask

  task automatic test_reset_mid();
    int q0;
    logic [7:0] g;
    send_tok(T_PUSH, 8'd1);
    send_tok(T_PUSH, 8'd2);
    send_tok(T_ADD, 8'd0);
    q0 = pop_cnt;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (stk_push !== 1'b0 || stk_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle_strobe: push=%b pop=%b required 0 0", stk_push, stk_pop);
    end
    @(posedge clk);
    #2;
    model_reset();
    n_checks++;
    if ({tok_ready, stk_push, stk_pop, res_valid, err, err_code, stk_din} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b required 0", {tok_ready, stk_push, stk_pop, res_valid, err, err_code, stk_din});
    end
    @(negedge clk);
    n_checks++;
    if (pop_cnt !== q0 + 1) begin
      n_fail++;
      $display("FAIL reset_mid_pops: got %0d required %0d", pop_cnt, q0 + 1);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (tok_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b required 1", tok_ready);
    end
    send_tok(T_PUSH, 8'h9A);
    send_tok(T_RESULT, 8'd0);
    wait_ready();
    g = (got_res.size() > 0) ? got_res[0] : 8'h00;
    n_checks++;
    if (got_res.size() != 1 || g !== 8'h9A || exp_res.size() != 1) begin
      n_fail++;
      $display("FAIL reset_mid_push: got %h (count %0d) required 9a", g, got_res.size());
    end
  endtask

  task automatic test_no_conflict();
    n_checks++;
    if (both_hi !== 1'b0) begin
      n_fail++;
      $display("FAIL push_pop_overlap: got %b required 0", both_hi);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub_xor();
    test_back_to_back();
    test_underflow();
    test_overflow_and_err();
    test_random();
    test_reset_mid();
    test_no_conflict();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
